// File: rtl/seg_display_ctrl_pkg.sv
// Shared I/O definitions for the seven-segment display peripheral.
package seg_display_ctrl_pkg;

  localparam logic [1:0] SEG_ADDR_LO   = 2'd0;
  localparam logic [1:0] SEG_ADDR_HI   = 2'd1;
  localparam logic [1:0] SEG_ADDR_MASK = 2'd2;
  localparam logic [1:0] SEG_ADDR_CTRL = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned SEG_CODE_W = 5;

endpackage

// File: rtl/seg_display_ctrl_segtrans.sv
// Hex-to-segment decoder: {enable, nibble} to active-low segments g..a.
module SegTrans
  import seg_display_ctrl_pkg::*;
(
  input  logic [SEG_CODE_W-1:0] code,
  output logic [6:0]            seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code[4]) begin
      unique case (code[3:0])
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed 8-digit seven-segment controller: register file, scan engine
// and a single output register so anodes and segments switch together.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

  logic [15:0]           lo, hi, mask;
  logic                  scan_en;
  logic [PW-1:0]         pcnt;
  logic [2:0]            idx;
  logic [31:0]           digits;
  logic [3:0]            nibble;
  logic [SEG_CODE_W-1:0] code;
  logic [6:0]            seg_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo      <= '0;
      hi      <= '0;
      mask    <= '0;
      scan_en <= 1'b0;
    end else if (cs && we) begin
      unique case (addr)
        SEG_ADDR_LO:   lo      <= wdata;
        SEG_ADDR_HI:   hi      <= wdata;
        SEG_ADDR_MASK: mask    <= wdata;
        SEG_ADDR_CTRL: scan_en <= wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (cs && !we) begin
      unique case (addr)
        SEG_ADDR_LO:   rdata <= lo;
        SEG_ADDR_HI:   rdata <= hi;
        SEG_ADDR_MASK: rdata <= mask;
        SEG_ADDR_CTRL: rdata <= {15'b0, scan_en};
        default:       rdata <= '0;
      endcase
    end
  end

  // The scan advances on the enable value held before this edge, so a write
  // to CTRL and a scan step on the same edge stay independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (scan_en) begin
      if (pcnt == PW'(SCAN_DIV - 1)) begin
        pcnt <= '0;
        idx  <= idx + 3'd1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  assign digits = {hi, lo};
  assign nibble = digits[{idx, 2'b00} +: 4];
  assign code   = {mask[idx], nibble};

  SegTrans u_segtrans (
    .code (code),
    .seg  (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (scan_en) begin
      an  <= ~(8'(1) << idx);
      seg <= seg_dec;
      dp  <= ~(mask[{1'b1, idx}] & mask[idx]);
    end else begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule
